// File: rtl/frame_burst_streamer.sv
// Frame-buffered burst streamer: collects FRAME_LEN beats per bank, then replays each frame as a gapless burst.
// Define FRAME_BURST_STREAMER_PINGPONG_EN for two banks (fill one while the other bursts); default is a single bank.
module frame_burst_streamer #(
    parameter int NO_CH         = 2,
    parameter int LOG2_IMG_SIZE = 10,
    parameter int SER_CYC       = 1,
    parameter int GAP_CYC       = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [NO_CH-1:0] in_data,
    output logic             out_vld,
    output logic [NO_CH-1:0] out_data,
    output logic             out_sof,
    output logic             out_eof
);

    localparam int AW        = LOG2_IMG_SIZE + $clog2(SER_CYC);
    localparam int FRAME_LEN = 1 << AW;
    localparam int GW        = $clog2(GAP_CYC + 1);

`ifdef FRAME_BURST_STREAMER_PINGPONG_EN
    localparam logic PP = 1'b1;
`else
    localparam logic PP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    // Bank index is the address MSB; in single-bank builds it stays 0.
    logic [NO_CH-1:0] mem_q [2*FRAME_LEN];

    logic [1:0]       full_q, full_d;
    logic             wr_bank_q, wr_bank_d;
    logic [AW-1:0]    wr_cnt_q, wr_cnt_d;
    logic             rd_bank_q;
    logic [AW-1:0]    rd_cnt_q;
    state_t           state_q;
    logic [GW-1:0]    gap_q;
    logic             out_vld_q, out_sof_q, out_eof_q;
    logic [NO_CH-1:0] out_data_q;
    logic             wr_en, wr_last, rd_free;

    always_comb begin
        in_rdy    = !full_q[wr_bank_q];
        wr_en     = in_vld && in_rdy;
        wr_last   = wr_en && (wr_cnt_q == '1);
        // The bank is released while its last beat is on the output.
        rd_free   = (state_q == BURST) && out_eof_q;
        wr_cnt_d  = wr_en ? wr_cnt_q + 1'b1 : wr_cnt_q;
        wr_bank_d = wr_last ? (PP & ~wr_bank_q) : wr_bank_q;
        full_d    = full_q;
        if (rd_free) full_d[rd_bank_q] = 1'b0;
        if (wr_last) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[{wr_bank_q, wr_cnt_q}] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q     <= '0;
            wr_bank_q  <= 1'b0;
            wr_cnt_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_cnt_q   <= '0;
            state_q    <= IDLE;
            gap_q      <= '0;
            out_vld_q  <= 1'b0;
            out_sof_q  <= 1'b0;
            out_eof_q  <= 1'b0;
            out_data_q <= '0;
        end else begin
            full_q     <= full_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_bank_q  <= wr_bank_d;
            out_vld_q  <= 1'b0;
            out_sof_q  <= 1'b0;
            out_eof_q  <= 1'b0;
            out_data_q <= '0;
            case (state_q)
                IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        state_q  <= BURST;
                        rd_cnt_q <= '0;
                    end
                end
                BURST: begin
                    if (out_eof_q) begin
                        state_q   <= GAP;
                        gap_q     <= '0;
                        rd_bank_q <= PP & ~rd_bank_q;
                    end else begin
                        out_vld_q  <= 1'b1;
                        out_data_q <= mem_q[{rd_bank_q, rd_cnt_q}];
                        out_sof_q  <= (rd_cnt_q == '0);
                        out_eof_q  <= (rd_cnt_q == '1);
                        rd_cnt_q   <= rd_cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == GW'(GAP_CYC - 1)) state_q <= IDLE;
                    else gap_q <= gap_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_vld  = out_vld_q;
    assign out_data = out_data_q;
    assign out_sof  = out_sof_q;
    assign out_eof  = out_eof_q;

endmodule

// File: tb/tb_frame_burst_streamer.sv
// Randomized bench for frame_burst_streamer: a cycle-schedule model predicts in_rdy and every output beat.
module tb_frame_burst_streamer;

    localparam int NO_CH = 2;
    localparam int L2    = 3;
    localparam int GAP   = 2;
    localparam int FL    = 8;
`ifdef FRAME_BURST_STREAMER_PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_vld = 1'b0;
    logic             in_rdy;
    logic [NO_CH-1:0] in_data = '0;
    logic             out_vld, out_sof, out_eof;
    logic [NO_CH-1:0] out_data;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int last_hs = 0;

    frame_burst_streamer #(
        .NO_CH(NO_CH), .LOG2_IMG_SIZE(L2), .SER_CYC(1), .GAP_CYC(GAP)
    ) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
        .out_vld(out_vld), .out_data(out_data), .out_sof(out_sof), .out_eof(out_eof)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
    endtask

    // Model: each completed frame is scheduled as a burst starting 3 cycles after completion,
    // or GAP+3 cycles after the previous burst's last beat if that is later; its bank is freed
    // the cycle after that last beat. in_rdy is high while fewer than NB frames are held.
    typedef struct packed {
        logic             s;
        logic             e;
        logic [NO_CH-1:0] d;
    } beat_t;

    beat_t            sched[int];
    int               free_at[int];
    logic [NO_CH-1:0] frm[$];
    int               held = 0;
    int               pend_inc = 0;
    int               mdl_last_eof = -1000;
    bit               armed = 1'b0;

    initial begin
        int    t, st;
        bit    erdy, ev;
        beat_t eb, nb;
        forever begin
            @(negedge clk);
            t = cyc;
            held = held + pend_inc;
            pend_inc = 0;
            if (free_at.exists(t)) held = held - free_at[t];
            erdy = (held < NB);
            ev = sched.exists(t);
            eb = ev ? sched[t] : '0;
            if (armed) begin
                chk("in_rdy", in_rdy, erdy);
                chk("out_vld", out_vld, ev);
                chk("out_data", out_data, eb.d);
                chk("out_sof", out_sof, eb.s);
                chk("out_eof", out_eof, eb.e);
            end
            if (rst) begin
                sched.delete();
                free_at.delete();
                frm.delete();
                held = 0;
                mdl_last_eof = -1000;
                armed = 1'b1;
            end else if (armed && in_vld && erdy) begin
                frm.push_back(in_data);
                if (frm.size() == FL) begin
                    st = (t + 3 > mdl_last_eof + GAP + 3) ? t + 3 : mdl_last_eof + GAP + 3;
                    for (int i = 0; i < FL; i++) begin
                        nb.s = (i == 0);
                        nb.e = (i == FL - 1);
                        nb.d = frm[i];
                        sched[st + i] = nb;
                    end
                    mdl_last_eof = st + FL - 1;
                    free_at[mdl_last_eof + 1] = 1;
                    pend_inc = 1;
                    frm.delete();
                end
            end
        end
    end

    task automatic send(input int n, input int mode, input bit seq);
        int acc, g;
        acc = 0;
        g = 0;
        while (acc < n && g < 400) begin
            @(posedge clk); #1;
            case (mode)
                0:       in_vld = 1'b1;
                1:       in_vld = (g % 2 == 0);
                default: in_vld = ($urandom_range(0, 3) != 0);
            endcase
            in_data = seq ? NO_CH'(acc % 4) : NO_CH'($urandom);
            @(negedge clk);
            if (in_vld && in_rdy) begin
                acc++;
                last_hs = cyc;
            end
            g++;
        end
        @(posedge clk); #1 in_vld = 1'b0;
        if (acc < n) begin
            n_chk++;
            $display("FAIL send_timeout: accepted %0d required %0d", acc, n);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int               lit[8];
        logic [NO_CH-1:0] got[8];
        bit               gs[8], ge[8];
        int               first, n, cnt, g, e;
        lit = '{0, 1, 2, 3, 0, 1, 2, 3};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_rdy", in_rdy, 1);
        chk("reset_out_vld", out_vld, 0);
        chk("reset_out_data", out_data, 0);

        // Sequential data, continuous valid: pin latency, length and content.
        send(8, 0, 1'b1);
        first = -1;
        n = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (out_vld) begin
                if (first < 0) first = cyc;
                if (n < 8) begin
                    got[n] = out_data;
                    gs[n] = out_sof;
                    ge[n] = out_eof;
                end
                n++;
            end
        end
        chk("t1_latency", first - last_hs, 3);
        chk("t1_len", n, 8);
        for (int i = 0; i < 8; i++) chk("t1_data", got[i], lit[i]);
        chk("t1_sof0", gs[0], 1);
        chk("t1_eof7", ge[7], 1);
        chk("t1_eof0", ge[0], 0);
        idle(5);

        send(8, 1, 1'b0);
        idle(30);

        send(24, 0, 1'b0);
        idle(60);

        // Reset while beat 4 of a burst is on the output.
        send(8, 0, 1'b0);
        cnt = 0;
        g = 0;
        while (cnt < 4 && g < 40) begin
            @(negedge clk);
            if (out_vld) cnt++;
            g++;
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_vld", out_vld, 0);
        chk("rst_mid_in_rdy", in_rdy, 1);
        send(8, 0, 1'b0);
        idle(30);

        // Reset in the middle of a fill; partial frame is dropped.
        send(5, 0, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        send(8, 2, 1'b0);
        idle(30);

`ifdef FRAME_BURST_STREAMER_PINGPONG_EN
        // Second frame completes in the same cycle the first one shows out_eof.
        send(8, 0, 1'b0);
        e = mdl_last_eof;
        send(7, 0, 1'b0);
        while (cyc < e) begin
            @(posedge clk); #1;
        end
        in_vld = 1'b1;
        in_data = NO_CH'($urandom);
        @(negedge clk);
        @(posedge clk); #1 in_vld = 1'b0;
        chk("coinc_model_eof", mdl_last_eof - e, GAP + 3 + 7);
        idle(30);
`endif

        for (int r = 0; r < 4; r++) send(8 + $urandom_range(0, 16), 2, 1'b0);
        idle(80);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
